// File: rtl/gb_video_mem_responder.sv
// Video memory responder: VRAM/OAM storage, PPU and CPU read ports, mode locking, OAM DMA engine.
// Latency: PPU and CPU reads return registered data 1 clock after the strobe; DMA moves 1 byte per 2 clocks.
// Backpressure: none; blocked CPU accesses read 0xFF and drop writes. Optional lock: VMEM_ACCESS_LOCK_EN.
module gb_video_mem_responder (
    input  logic        clk,
    input  logic        rst,
    input  logic        PPU_RD,
    input  logic [15:0] PPU_ADDR,
    output logic [7:0]  PPU_DATA,
    input  logic [1:0]  PPU_MODE,
    input  logic        LCD_ON,
    input  logic [15:0] ADDR,
    input  logic        WR,
    input  logic        RD,
    input  logic [7:0]  MMIO_DATA_out,
    output logic [7:0]  MEM_DATA_in,
    output logic        DMA_RD,
    output logic [15:0] DMA_ADDR,
    input  logic [7:0]  DMA_DATA_in,
    output logic        DMA_ACTIVE
);

    typedef enum logic [1:0] {
        DMA_IDLE  = 2'd0,
        DMA_REQ   = 2'd1,
        DMA_WRITE = 2'd2
    } dma_state_t;

    logic [7:0] r_vram [0:8191];
    logic [7:0] r_oam  [0:159];

    dma_state_t r_state;
    dma_state_t w_state_nxt;
    logic [7:0] r_idx;
    logic [7:0] w_idx_nxt;
    logic [7:0] r_base;
    logic [7:0] w_base_nxt;
    logic       w_dma_we;

    logic [7:0] r_ppu_data;
    logic [7:0] r_mem_data;

    logic       w_cpu_vram;
    logic       w_cpu_oam;
    logic       w_ppu_vram;
    logic       w_ppu_oam;
    logic       w_vram_lock;
    logic       w_oam_lock;
    logic       w_dma_active;
    logic       w_cpu_blocked;
    logic       w_dma_trig;
    logic [7:0] w_trig_base;
    logic       w_vram_we;
    logic       w_oam_we;
    logic [7:0] w_oam_waddr;
    logic [7:0] w_oam_wdata;
    logic [7:0] w_ppu_rdata;
    logic [7:0] w_cpu_rdata;

    assign w_cpu_vram   = (ADDR[15:13] == 3'b100);
    assign w_cpu_oam    = (ADDR[15:8] == 8'hFE) && (ADDR[7:0] < 8'hA0);
    assign w_ppu_vram   = (PPU_ADDR[15:13] == 3'b100);
    assign w_ppu_oam    = (PPU_ADDR[15:8] == 8'hFE) && (PPU_ADDR[7:0] < 8'hA0);
    assign w_dma_active = (r_state != DMA_IDLE);

`ifdef VMEM_ACCESS_LOCK_EN
    assign w_vram_lock = LCD_ON && (PPU_MODE == 2'd3);
    assign w_oam_lock  = LCD_ON && PPU_MODE[1];
`else
    assign w_vram_lock = 1'b0;
    assign w_oam_lock  = 1'b0;
`endif

    assign w_cpu_blocked = (w_cpu_vram && w_vram_lock) ||
                           (w_cpu_oam && (w_oam_lock || w_dma_active));

    // Echo-RAM sources (0xE0xx and up) fold back onto work RAM.
    assign w_dma_trig  = WR && (ADDR == 16'hFF46);
    assign w_trig_base = (MMIO_DATA_out >= 8'hE0) ? (MMIO_DATA_out - 8'h20) : MMIO_DATA_out;

    // DMA next-state: a trigger always restarts; otherwise alternate REQ/WRITE over 160 bytes.
    always_comb begin
        w_state_nxt = r_state;
        w_idx_nxt   = r_idx;
        w_base_nxt  = r_base;
        w_dma_we    = 1'b0;
        if (w_dma_trig) begin
            w_state_nxt = DMA_REQ;
            w_idx_nxt   = 8'd0;
            w_base_nxt  = w_trig_base;
        end else begin
            case (r_state)
                DMA_IDLE: w_state_nxt = DMA_IDLE;
                DMA_REQ:  w_state_nxt = DMA_WRITE;
                DMA_WRITE: begin
                    w_dma_we = 1'b1;
                    if (r_idx == 8'd159) begin
                        w_state_nxt = DMA_IDLE;
                    end else begin
                        w_idx_nxt   = r_idx + 8'd1;
                        w_state_nxt = DMA_REQ;
                    end
                end
                default: w_state_nxt = DMA_IDLE;
            endcase
        end
    end

    // DMA state, index and source base registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= DMA_IDLE;
            r_idx   <= 8'd0;
            r_base  <= 8'd0;
        end else begin
            r_state <= w_state_nxt;
            r_idx   <= w_idx_nxt;
            r_base  <= w_base_nxt;
        end
    end

    // OAM write port: DMA has priority (CPU OAM writes are blocked during DMA anyway).
    assign w_vram_we   = WR && w_cpu_vram && !w_cpu_blocked;
    assign w_oam_we    = w_dma_we || (WR && w_cpu_oam && !w_cpu_blocked);
    assign w_oam_waddr = w_dma_we ? r_idx : ADDR[7:0];
    assign w_oam_wdata = w_dma_we ? DMA_DATA_in : MMIO_DATA_out;

    // Memory arrays are not reset; contents survive a reset.
    always_ff @(posedge clk) begin
        if (w_vram_we) begin
            r_vram[ADDR[12:0]] <= MMIO_DATA_out;
        end
        if (w_oam_we) begin
            r_oam[w_oam_waddr] <= w_oam_wdata;
        end
    end

    assign w_ppu_rdata = w_ppu_vram ? r_vram[PPU_ADDR[12:0]] :
                         (w_ppu_oam && !w_dma_active) ? r_oam[PPU_ADDR[7:0]] : 8'hFF;
    assign w_cpu_rdata = w_cpu_blocked ? 8'hFF :
                         w_cpu_vram ? r_vram[ADDR[12:0]] :
                         w_cpu_oam  ? r_oam[ADDR[7:0]] : 8'hFF;

    // Registered read data; array reads see pre-write contents on same-cycle collisions.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_ppu_data <= 8'h00;
            r_mem_data <= 8'hFF;
        end else begin
            if (PPU_RD) begin
                r_ppu_data <= w_ppu_rdata;
            end
            if (RD) begin
                r_mem_data <= w_cpu_rdata;
            end
        end
    end

    assign PPU_DATA    = r_ppu_data;
    assign MEM_DATA_in = r_mem_data;
    assign DMA_RD      = (r_state == DMA_REQ);
    assign DMA_ADDR    = {r_base, r_idx};
    assign DMA_ACTIVE  = w_dma_active;

endmodule

// File: tb/tb_gb_video_mem_responder.sv
// Bench for gb_video_mem_responder: directed scenarios plus randomized traffic.
// Outputs compared each falling edge against a transaction-level model of the memories and DMA.
// DMA source returns (low address byte + salt) one clock after DMA_RD.
module tb_gb_video_mem_responder;

`ifdef VMEM_ACCESS_LOCK_EN
    localparam bit LOCK = 1'b1;
`else
    localparam bit LOCK = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        PPU_RD = 1'b0;
    logic [15:0] PPU_ADDR = 16'h0000;
    logic [7:0]  PPU_DATA;
    logic [1:0]  PPU_MODE = 2'd0;
    logic        LCD_ON = 1'b1;
    logic [15:0] ADDR = 16'h0000;
    logic        WR = 1'b0;
    logic        RD = 1'b0;
    logic [7:0]  MMIO_DATA_out = 8'h00;
    logic [7:0]  MEM_DATA_in;
    logic        DMA_RD;
    logic [15:0] DMA_ADDR;
    logic [7:0]  DMA_DATA_in = 8'h00;
    logic        DMA_ACTIVE;

    int checks = 0;
    int errors = 0;
    logic [7:0] src_salt = 8'h00;

    gb_video_mem_responder dut (
        .clk(clk), .rst(rst),
        .PPU_RD(PPU_RD), .PPU_ADDR(PPU_ADDR), .PPU_DATA(PPU_DATA),
        .PPU_MODE(PPU_MODE), .LCD_ON(LCD_ON),
        .ADDR(ADDR), .WR(WR), .RD(RD),
        .MMIO_DATA_out(MMIO_DATA_out), .MEM_DATA_in(MEM_DATA_in),
        .DMA_RD(DMA_RD), .DMA_ADDR(DMA_ADDR), .DMA_DATA_in(DMA_DATA_in),
        .DMA_ACTIVE(DMA_ACTIVE)
    );

    always #5 clk = ~clk;

    // DMA source memory: data valid the cycle after the read strobe.
    always @(posedge clk) begin
        if (DMA_RD) DMA_DATA_in <= DMA_ADDR[7:0] + src_salt;
    end

    task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic bit is_v(input logic [15:0] a);
        return (a >= 16'h8000) && (a <= 16'h9FFF);
    endfunction

    function automatic bit is_o(input logic [15:0] a);
        return (a >= 16'hFE00) && (a <= 16'hFE9F);
    endfunction

    // ---------------- reference model ----------------
    logic [7:0]  vram_m [8192];
    bit          vram_k [8192];
    logic [7:0]  oam_m  [160];
    bit          oam_k  [160];
    logic [7:0]  exp_ppu, exp_mem;
    bit          ppu_k, mem_k, m_started = 1'b0;
    bit          m_on;
    logic [8:0]  m_c;
    logic [7:0]  m_base;
    logic [15:0] m_addr;

    always @(posedge clk) begin : model
        bit blk;
        logic [8:0] nc;
        logic [7:0] nbase;
        if (!rst) begin
            m_started <= 1'b1;
            exp_ppu <= 8'h00; ppu_k <= 1'b1;
            exp_mem <= 8'hFF; mem_k <= 1'b1;
            m_on <= 1'b0; m_c <= 9'd0; m_base <= 8'h00; m_addr <= 16'h0000;
        end else begin
            blk = (is_v(ADDR) && LOCK && LCD_ON && PPU_MODE == 2'd3) ||
                  (is_o(ADDR) && ((LOCK && LCD_ON && PPU_MODE >= 2'd2) || m_on));
            if (PPU_RD) begin
                if (is_v(PPU_ADDR)) begin
                    exp_ppu <= vram_m[PPU_ADDR[12:0]]; ppu_k <= vram_k[PPU_ADDR[12:0]];
                end else if (is_o(PPU_ADDR) && !m_on) begin
                    exp_ppu <= oam_m[PPU_ADDR[7:0]]; ppu_k <= oam_k[PPU_ADDR[7:0]];
                end else begin
                    exp_ppu <= 8'hFF; ppu_k <= 1'b1;
                end
            end
            if (RD) begin
                if (blk || !(is_v(ADDR) || is_o(ADDR))) begin
                    exp_mem <= 8'hFF; mem_k <= 1'b1;
                end else if (is_v(ADDR)) begin
                    exp_mem <= vram_m[ADDR[12:0]]; mem_k <= vram_k[ADDR[12:0]];
                end else begin
                    exp_mem <= oam_m[ADDR[7:0]]; mem_k <= oam_k[ADDR[7:0]];
                end
            end
            if (WR && !blk) begin
                if (is_v(ADDR)) begin
                    vram_m[ADDR[12:0]] <= MMIO_DATA_out; vram_k[ADDR[12:0]] <= 1'b1;
                end else if (is_o(ADDR)) begin
                    oam_m[ADDR[7:0]] <= MMIO_DATA_out; oam_k[ADDR[7:0]] <= 1'b1;
                end
            end
            if (WR && ADDR == 16'hFF46) begin
                nbase = (MMIO_DATA_out >= 8'hE0) ? MMIO_DATA_out - 8'h20 : MMIO_DATA_out;
                m_base <= nbase; m_on <= 1'b1; m_c <= 9'd0; m_addr <= {nbase, 8'h00};
            end else if (m_on) begin
                // Odd step of the 320-clock transfer: byte m_c/2 lands in OAM.
                if (m_c[0]) begin
                    oam_m[m_c[8:1]] <= DMA_DATA_in; oam_k[m_c[8:1]] <= 1'b1;
                end
                nc = m_c + 9'd1;
                m_c <= nc;
                if (nc == 9'd320) m_on <= 1'b0;
                else m_addr <= {m_base, 8'h00} + {8'h00, nc[8:1]};
            end
        end
    end

    // Compare process: every falling edge while out of reset.
    always @(negedge clk) begin
        if (rst && m_started) begin
            if (ppu_k) chk("ppu_data", {8'h00, PPU_DATA}, {8'h00, exp_ppu});
            if (mem_k) chk("mem_data", {8'h00, MEM_DATA_in}, {8'h00, exp_mem});
            chk("dma_rd", {15'h0, DMA_RD}, {15'h0, m_on && !m_c[0]});
            chk("dma_active", {15'h0, DMA_ACTIVE}, {15'h0, m_on});
            chk("dma_addr", DMA_ADDR, m_addr);
        end
    end

    // ---------------- stimulus ----------------
    task automatic drive(input logic wr, input logic rd, input logic [15:0] a, input logic [7:0] d,
                         input logic prd, input logic [15:0] pa);
        @(negedge clk);
        WR = wr; RD = rd; ADDR = a; MMIO_DATA_out = d; PPU_RD = prd; PPU_ADDR = pa;
    endtask

    task automatic idle();                                         drive(1'b0, 1'b0, 16'h0000, 8'h00, 1'b0, 16'h0000); endtask
    task automatic cpu_wr(input logic [15:0] a, input logic [7:0] d); drive(1'b1, 1'b0, a, d, 1'b0, 16'h0000); endtask
    task automatic cpu_rd(input logic [15:0] a);                   drive(1'b0, 1'b1, a, 8'h00, 1'b0, 16'h0000); endtask
    task automatic ppu_rd(input logic [15:0] a);                   drive(1'b0, 1'b0, 16'h0000, 8'h00, 1'b1, a); endtask

    function automatic logic [15:0] rnd_addr();
        logic [15:0] odd [4];
        odd[0] = 16'h7FFF; odd[1] = 16'hA000; odd[2] = 16'hFEA0; odd[3] = 16'hFF00;
        case ($urandom_range(0, 9))
            0, 1, 2, 3: return 16'h8000 + 16'($urandom_range(0, 15));
            4:          return 16'h9FFF;
            5, 6, 7:    return 16'hFE00 + 16'($urandom_range(0, 15));
            8:          return 16'hFE9F;
            default:    return odd[$urandom_range(0, 3)];
        endcase
    endfunction

    initial begin
        int cnt, nreq;
        repeat (3) @(negedge clk);
        chk("rst_ppu_data", {8'h00, PPU_DATA}, 16'h0000);
        chk("rst_mem_data", {8'h00, MEM_DATA_in}, 16'h00FF);
        chk("rst_dma_rd", {15'h0, DMA_RD}, 16'h0000);
        chk("rst_dma_addr", DMA_ADDR, 16'h0000);
        chk("rst_dma_active", {15'h0, DMA_ACTIVE}, 16'h0000);
        rst = 1'b1;

        // VRAM write/read in mode 0
        PPU_MODE = 2'd0; LCD_ON = 1'b1;
        cpu_wr(16'h8010, 8'h5A); cpu_rd(16'h8010); idle();
        chk("vram_cpu_rd", {8'h00, MEM_DATA_in}, 16'h005A);
        ppu_rd(16'h8010); idle();
        chk("vram_ppu_rd", {8'h00, PPU_DATA}, 16'h005A);

        // VRAM access in mode 3
        cpu_wr(16'h9800, 8'h11); idle();
        PPU_MODE = 2'd3;
        cpu_wr(16'h9800, 8'h77); cpu_rd(16'h9800); idle();
        chk("vram_mode3_rd", {8'h00, MEM_DATA_in}, LOCK ? 16'h00FF : 16'h0077);
        ppu_rd(16'h9800); idle();
        chk("vram_mode3_ppu", {8'h00, PPU_DATA}, LOCK ? 16'h0011 : 16'h0077);
        PPU_MODE = 2'd0;
        cpu_rd(16'h9800); idle();
        chk("vram_mode0_rd", {8'h00, MEM_DATA_in}, LOCK ? 16'h0011 : 16'h0077);

        // OAM access in modes 2 and 1
        PPU_MODE = 2'd1;
        cpu_wr(16'hFE00, 8'h00); idle();
        PPU_MODE = 2'd2;
        cpu_wr(16'hFE00, 8'h33); ppu_rd(16'hFE00); idle();
        chk("oam_mode2_wr", {8'h00, PPU_DATA}, LOCK ? 16'h0000 : 16'h0033);
        PPU_MODE = 2'd1;
        cpu_wr(16'hFE00, 8'h33); ppu_rd(16'hFE00); idle();
        chk("oam_mode1_wr", {8'h00, PPU_DATA}, 16'h0033);

        // DMA from 0xC100, with PPU and CPU hammering OAM throughout
        PPU_MODE = 2'd0;
        cpu_wr(16'hFF46, 8'hC1);
        cnt = 0; nreq = 0;
        for (int i = 0; i < 400; i++) begin
            drive(1'b0, 1'b1, 16'hFE10, 8'h00, 1'b1, 16'hFE00 + 16'(i % 160));
            if (DMA_ACTIVE) cnt++;
            else if (cnt > 0) break;
            if (DMA_RD) begin
                chk("dma_addr_seq", DMA_ADDR, 16'hC100 + 16'(nreq));
                nreq++;
            end
            if (i == 5) chk("oam_rd_during_dma", {8'h00, MEM_DATA_in}, 16'h00FF);
        end
        chk("dma_active_len", 16'(cnt), 16'd320);
        chk("dma_req_count", 16'(nreq), 16'd160);
        for (int k = 0; k <= 160; k++) begin
            if (k < 160) ppu_rd(16'hFE00 + 16'(k));
            else idle();
            if (k > 0) chk("oam_after_dma", {8'h00, PPU_DATA}, 16'(k - 1));
        end

        // Echo base and restart mid-transfer
        src_salt = 8'h40;
        cpu_wr(16'hFF46, 8'hE2); idle();
        chk("echo_base", DMA_ADDR, 16'hC200);
        chk("echo_req", {15'h0, DMA_RD}, 16'h0001);
        repeat (100) idle();
        chk("idx50_addr", DMA_ADDR, 16'hC232);
        cpu_wr(16'hFF46, 8'h80); idle();
        chk("restart_addr", DMA_ADDR, 16'h8000);
        repeat (330) idle();
        chk("restart_done", {15'h0, DMA_ACTIVE}, 16'h0000);
        chk("addr_holds", DMA_ADDR, 16'h809F);

        // Randomized traffic
        for (int i = 0; i < 16; i++) cpu_wr(16'h8000 + 16'(i), 8'($urandom));
        cpu_wr(16'h9FFF, 8'($urandom));
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 299) == 0)
                drive(1'b1, 1'($urandom), 16'hFF46, 8'($urandom), 1'($urandom), rnd_addr());
            else
                drive(1'($urandom), 1'($urandom), rnd_addr(), 8'($urandom), 1'($urandom), rnd_addr());
            PPU_MODE = 2'($urandom); LCD_ON = 1'($urandom);
        end
        idle(); repeat (330) idle();
        PPU_MODE = 2'd0; LCD_ON = 1'b1;

        // Reset in the middle of a DMA
        src_salt = 8'h90;
        cpu_wr(16'hFF46, 8'hC3);
        repeat (37) idle();
        #2 rst = 1'b0;
        #1;
        chk("rst_mid_active", {15'h0, DMA_ACTIVE}, 16'h0000);
        chk("rst_mid_rd", {15'h0, DMA_RD}, 16'h0000);
        chk("rst_mid_mem", {8'h00, MEM_DATA_in}, 16'h00FF);
        chk("rst_mid_addr", DMA_ADDR, 16'h0000);
        repeat (3) idle();
        rst = 1'b1;
        ppu_rd(16'hFE00); ppu_rd(16'hFE1E);
        chk("kept_oam0", {8'h00, PPU_DATA}, 16'h0090);
        idle();
        chk("old_oam30", {8'h00, PPU_DATA}, 16'h005E);
        repeat (4) idle();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
